// File: rtl/dram_host_rs_pkg.sv
// -----------------------------------------------------------------------------
// dram_host_rs_pkg
// Shared definitions for the host-side DRAM reservation station:
//   - station FSM state encoding (RS_IDLE/RS_REQ/RS_XFER/RS_RSP)
//   - default line geometry (beats per line, beat counter width)
//   - beat and per-beat byte-mask widths
// Optional feature macro used by the importing files: DRAM_RS_BYTEMASK_EN.
// -----------------------------------------------------------------------------
package dram_host_rs_pkg;

  localparam int unsigned RS_DEFAULT_BEATS = 8;
  localparam int unsigned RS_DEFAULT_CW    = 3;
  localparam int unsigned RS_BEAT_W        = 16;
  localparam int unsigned RS_MASK_W        = 2;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_REQ  = 2'd1,
    RS_XFER = 2'd2,
    RS_RSP  = 2'd3
  } rs_state_e;

endpackage

// File: rtl/dram_rs_linebuf.sv
// -----------------------------------------------------------------------------
// dram_rs_linebuf
// One-line register file for the reservation station: BEATS x 16-bit data
// (plus BEATS x 2-bit byte mask when DRAM_RS_BYTEMASK_EN is defined).
// Parallel load of a whole line, single-beat indexed write, indexed read and a
// flat view of the full line. Asynchronous active-high reset clears all slots.
// Ports:
//   clk, rst       clock, async active-high reset
//   i_load         load whole line from i_load_data (and i_load_mask)
//   i_load_data    line, beat i = bits[16i+15:16i]
//   i_load_mask    per-beat byte mask, beat i = bits[2i+1:2i] (macro only)
//   i_wr           write i_wr_data into slot i_idx (ignored while i_load)
//   i_idx          slot index for write and for o_rd_data/o_rd_mask
//   i_wr_data      beat to write
//   o_rd_data      data of slot i_idx
//   o_rd_mask      mask of slot i_idx (macro only)
//   o_line         whole line, same packing as i_load_data
// Configuration macro: DRAM_RS_BYTEMASK_EN adds the mask storage and ports.
// -----------------------------------------------------------------------------
module dram_rs_linebuf
  import dram_host_rs_pkg::*;
#(
  parameter int unsigned BEATS = RS_DEFAULT_BEATS,
  parameter int unsigned CW    = RS_DEFAULT_CW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_load,
  input  logic [RS_BEAT_W*BEATS-1:0]   i_load_data,
`ifdef DRAM_RS_BYTEMASK_EN
  input  logic [RS_MASK_W*BEATS-1:0]   i_load_mask,
  output logic [RS_MASK_W-1:0]         o_rd_mask,
`endif
  input  logic                         i_wr,
  input  logic [CW-1:0]                i_idx,
  input  logic [RS_BEAT_W-1:0]         i_wr_data,
  output logic [RS_BEAT_W-1:0]         o_rd_data,
  output logic [RS_BEAT_W*BEATS-1:0]   o_line
);

  logic [RS_BEAT_W-1:0] r_data [BEATS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BEATS; i++) r_data[i] <= '0;
    end else if (i_load) begin
      for (int i = 0; i < BEATS; i++) r_data[i] <= i_load_data[RS_BEAT_W*i +: RS_BEAT_W];
    end else if (i_wr) begin
      r_data[i_idx] <= i_wr_data;
    end
  end

  always_comb begin
    o_line = '0;
    for (int i = 0; i < BEATS; i++) o_line[RS_BEAT_W*i +: RS_BEAT_W] = r_data[i];
  end

  assign o_rd_data = r_data[i_idx];

`ifdef DRAM_RS_BYTEMASK_EN
  logic [RS_MASK_W-1:0] r_mask [BEATS];

  // Masks only change with a line load; read beats never carry a mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BEATS; i++) r_mask[i] <= '0;
    end else if (i_load) begin
      for (int i = 0; i < BEATS; i++) r_mask[i] <= i_load_mask[RS_MASK_W*i +: RS_MASK_W];
    end
  end

  assign o_rd_mask = r_mask[i_idx];
`endif

endmodule

// File: rtl/dram_host_rs.sv
// -----------------------------------------------------------------------------
// dram_host_rs
// Host-side reservation station in front of ram_hub. Accepts one cache-line
// (BEATS beats) or single-halfword request, drives the hub host_* handshake,
// streams write beats on host_txd_ack / captures read beats on host_rxd_vld,
// and signals completion with a 1-cycle rsp_vld pulse. One transaction at a time.
// Ports:
//   clk, rst        clock, async active-high reset (aborts any transaction)
//   i_cmd_vld/o_cmd_rdy   request handshake (o_cmd_rdy high only when idle)
//   i_cmd_rwn       1 read, 0 write
//   i_cmd_burst     1 full line, 0 single halfword (beat 0)
//   i_cmd_addr      halfword address
//   i_cmd_wdata     write line, beat i = bits[16i+15:16i]
//   i_cmd_wmask     per-beat byte mask, 1 = byte not written (macro only)
//   o_rsp_vld       completion pulse
//   o_rsp_rdata     line buffer contents (read data valid while o_rsp_vld)
//   o_host_req/i_host_ack  hub request; req drops combinationally on ack
//   o_host_rwn, o_host_burst, o_host_addr  latched request attributes
//   o_host_txd, o_host_txm  current write beat and its byte mask
//   i_host_txd_ack  write beat consumed
//   i_host_rxd, i_host_rxd_vld  read beat
// Configuration macro: DRAM_RS_BYTEMASK_EN enables i_cmd_wmask and a live
// o_host_txm; without it o_host_txm is tied to 2'b00.
// -----------------------------------------------------------------------------
module dram_host_rs
  import dram_host_rs_pkg::*;
#(
  parameter int unsigned BEATS = RS_DEFAULT_BEATS,
  parameter int unsigned CW    = RS_DEFAULT_CW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_cmd_vld,
  output logic                         o_cmd_rdy,
  input  logic                         i_cmd_rwn,
  input  logic                         i_cmd_burst,
  input  logic [31:0]                  i_cmd_addr,
  input  logic [RS_BEAT_W*BEATS-1:0]   i_cmd_wdata,
`ifdef DRAM_RS_BYTEMASK_EN
  input  logic [RS_MASK_W*BEATS-1:0]   i_cmd_wmask,
`endif
  output logic                         o_rsp_vld,
  output logic [RS_BEAT_W*BEATS-1:0]   o_rsp_rdata,
  output logic                         o_host_req,
  output logic                         o_host_rwn,
  output logic                         o_host_burst,
  output logic [31:0]                  o_host_addr,
  input  logic                         i_host_ack,
  output logic [RS_MASK_W-1:0]         o_host_txm,
  output logic [RS_BEAT_W-1:0]         o_host_txd,
  input  logic                         i_host_txd_ack,
  input  logic [RS_BEAT_W-1:0]         i_host_rxd,
  input  logic                         i_host_rxd_vld
);

  rs_state_e       r_state, w_state_nxt;
  logic            r_rwn;
  logic            r_burst;
  logic [31:0]     r_addr;
  logic [CW-1:0]   r_beat_cnt;

  logic            w_accept;
  logic            w_active;
  logic            w_evt;
  logic            w_last;
  logic            w_buf_load;
  logic            w_buf_wr;

  assign w_accept = (r_state == RS_IDLE) && i_cmd_vld;

  // Beats are counted in REQ as well so an event coincident with host_ack is kept.
  assign w_active = (r_state == RS_REQ) || (r_state == RS_XFER);
  assign w_evt    = w_active && (r_rwn ? i_host_rxd_vld : i_host_txd_ack);
  assign w_last   = r_burst ? (r_beat_cnt == CW'(BEATS - 1)) : (r_beat_cnt == '0);

  // Reads leave the buffer untouched so a single read keeps the other beats.
  assign w_buf_load = w_accept && !i_cmd_rwn;
  assign w_buf_wr   = w_evt && r_rwn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RS_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_cmd_rdy   = 1'b0;
    o_rsp_vld   = 1'b0;
    o_host_req  = 1'b0;
    unique case (r_state)
      RS_IDLE: begin
        o_cmd_rdy = 1'b1;
        if (i_cmd_vld) w_state_nxt = RS_REQ;
      end
      RS_REQ: begin
        o_host_req = !i_host_ack;
        if (w_evt && w_last) begin
          w_state_nxt = RS_RSP;
        end else if (i_host_ack) begin
          w_state_nxt = RS_XFER;
        end
      end
      RS_XFER: begin
        if (w_evt && w_last) w_state_nxt = RS_RSP;
      end
      RS_RSP: begin
        o_rsp_vld   = 1'b1;
        w_state_nxt = RS_IDLE;
      end
      default: w_state_nxt = RS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rwn   <= 1'b1;
      r_burst <= 1'b0;
      r_addr  <= '0;
    end else if (w_accept) begin
      r_rwn   <= i_cmd_rwn;
      r_burst <= i_cmd_burst;
      r_addr  <= i_cmd_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_beat_cnt <= '0;
    end else if (w_evt) begin
      r_beat_cnt <= r_beat_cnt + CW'(1);
    end
  end

  assign o_host_rwn   = r_rwn;
  assign o_host_burst = r_burst;
  assign o_host_addr  = r_addr;

`ifdef DRAM_RS_BYTEMASK_EN
  logic [RS_MASK_W-1:0] w_rd_mask;
`endif

  dram_rs_linebuf #(
    .BEATS (BEATS),
    .CW    (CW)
  ) u_linebuf (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_buf_load),
    .i_load_data (i_cmd_wdata),
`ifdef DRAM_RS_BYTEMASK_EN
    .i_load_mask (i_cmd_wmask),
    .o_rd_mask   (w_rd_mask),
`endif
    .i_wr        (w_buf_wr),
    .i_idx       (r_beat_cnt),
    .i_wr_data   (i_host_rxd),
    .o_rd_data   (o_host_txd),
    .o_line      (o_rsp_rdata)
  );

`ifdef DRAM_RS_BYTEMASK_EN
  assign o_host_txm = w_rd_mask;
`else
  assign o_host_txm = 2'b00;
`endif

endmodule

// File: tb/tb_dram_host_rs.sv
// -----------------------------------------------------------------------------
// tb_dram_host_rs
// Self-checking bench for dram_host_rs: the bench plays cache and hub, keeps a
// behavioural model of the line buffer and checks handshake timing and data.
// -----------------------------------------------------------------------------
module tb_dram_host_rs;

  localparam int BEATS = 8;
  localparam int CW    = 3;
  localparam int LW    = 16 * BEATS;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_vld, cmd_rdy, cmd_rwn, cmd_burst;
  logic [31:0]     cmd_addr;
  logic [LW-1:0]   cmd_wdata;
  logic [2*BEATS-1:0] cmd_wmask;
  logic            rsp_vld;
  logic [LW-1:0]   rsp_rdata;
  logic            host_req, host_rwn, host_burst, host_ack;
  logic [31:0]     host_addr;
  logic [1:0]      host_txm;
  logic [15:0]     host_txd, host_rxd;
  logic            host_txd_ack, host_rxd_vld;

  always #5 clk = ~clk;

  dram_host_rs #(
    .BEATS (BEATS),
    .CW    (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_cmd_vld      (cmd_vld),
    .o_cmd_rdy      (cmd_rdy),
    .i_cmd_rwn      (cmd_rwn),
    .i_cmd_burst    (cmd_burst),
    .i_cmd_addr     (cmd_addr),
    .i_cmd_wdata    (cmd_wdata),
`ifdef DRAM_RS_BYTEMASK_EN
    .i_cmd_wmask    (cmd_wmask),
`endif
    .o_rsp_vld      (rsp_vld),
    .o_rsp_rdata    (rsp_rdata),
    .o_host_req     (host_req),
    .o_host_rwn     (host_rwn),
    .o_host_burst   (host_burst),
    .o_host_addr    (host_addr),
    .i_host_ack     (host_ack),
    .o_host_txm     (host_txm),
    .o_host_txd     (host_txd),
    .i_host_txd_ack (host_txd_ack),
    .i_host_rxd     (host_rxd),
    .i_host_rxd_vld (host_rxd_vld)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference line buffer: what the station must hold after each event.
  logic [15:0] m_line [BEATS];
  logic [1:0]  m_mask [BEATS];

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [LW-1:0] model_line();
    logic [LW-1:0] r;
    for (int i = 0; i < BEATS; i++) r[16*i +: 16] = m_line[i];
    return r;
  endfunction

  function automatic logic [1:0] model_txm(input int beat);
`ifdef DRAM_RS_BYTEMASK_EN
    return m_mask[beat];
`else
    return (beat >= 0) ? 2'b00 : 2'b00;
`endif
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BEATS; i++) begin
      m_line[i] = '0;
      m_mask[i] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_hub();
    host_ack     = 1'b0;
    host_txd_ack = 1'b0;
    host_rxd_vld = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy"},   cmd_rdy, 1);
    chk({tag, "_rsp"},   rsp_vld, 0);
    chk({tag, "_req"},   host_req, 0);
    chk({tag, "_rwn"},   host_rwn, 1);
    chk({tag, "_burst"}, host_burst, 0);
    chk({tag, "_addr"},  host_addr, 0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
    chk({tag, "_txd"},   host_txd, 0);
    chk({tag, "_txm"},   host_txm, 0);
  endtask

  // Presents one beat event of the right kind for the current transaction.
  task automatic do_beat(input logic rwn, input logic [LW-1:0] rdata, inout int beat);
    if (rwn) begin
      host_rxd_vld = 1'b1;
      host_rxd     = rdata[16*beat +: 16];
      m_line[beat] = host_rxd;
    end else begin
      chk("txd_beat", host_txd, m_line[beat]);
      chk("txm_beat", host_txm, model_txm(beat));
      host_txd_ack = 1'b1;
    end
    beat++;
  endtask

  // Runs one complete transaction starting at an idle cycle; returns one cycle after RSP.
  task automatic run_txn(input logic rwn, input logic burst, input logic [31:0] addr,
                         input logic [LW-1:0] wdata, input logic [2*BEATS-1:0] wmask,
                         input logic [LW-1:0] rdata, input int ack_dly, input bit coin,
                         input int gap_min, input int gap_max);
    int nb;
    int beat;
    int gap;
    nb   = burst ? BEATS : 1;
    beat = 0;
    cmd_vld   = 1'b1;
    cmd_rwn   = rwn;
    cmd_burst = burst;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wmask = wmask;
    // Beat events while idle must be ignored.
    host_rxd_vld = 1'($urandom_range(0, 1));
    host_txd_ack = 1'($urandom_range(0, 1));
    host_rxd     = 16'($urandom);
    #1 chk("rdy_idle", cmd_rdy, 1);
    tick();
    clr_hub();
    cmd_vld   = 1'b0;
    cmd_wdata = rand_line();
    cmd_wmask = 16'($urandom);
    if (!rwn) begin
      for (int i = 0; i < BEATS; i++) begin
        m_line[i] = wdata[16*i +: 16];
`ifdef DRAM_RS_BYTEMASK_EN
        m_mask[i] = wmask[2*i +: 2];
`endif
      end
    end
    chk("rdy_busy", cmd_rdy, 0);
    chk("host_rwn", host_rwn, rwn);
    chk("host_burst", host_burst, burst);
    chk("host_addr", host_addr, addr);
    for (int d = 0; d < ack_dly; d++) begin
      // Wrong-direction events while waiting for ack must be ignored.
      if (rwn) host_txd_ack = 1'b1;
      else host_rxd_vld = 1'b1;
      #1 chk("req_wait", host_req, 1);
      tick();
      clr_hub();
    end
    host_ack = 1'b1;
    if (coin) do_beat(rwn, rdata, beat);
    #1 chk("req_drop", host_req, 0);
    tick();
    clr_hub();
    while (beat < nb) begin
      gap = $urandom_range(gap_max, gap_min);
      for (int g = 0; g < gap; g++) begin
        if (rwn) host_txd_ack = 1'($urandom_range(0, 1));
        else begin
          host_rxd_vld = 1'($urandom_range(0, 1));
          host_rxd     = 16'($urandom);
        end
        #1 chk("gap_req", host_req, 0);
        chk("gap_rsp", rsp_vld, 0);
        tick();
        clr_hub();
      end
      do_beat(rwn, rdata, beat);
      #1 chk("xfer_rsp", rsp_vld, 0);
      tick();
      clr_hub();
    end
    // Beat events during RSP must be ignored.
    host_rxd_vld = 1'b1;
    host_txd_ack = 1'b1;
    host_rxd     = 16'($urandom);
    chk("rsp_vld", rsp_vld, 1);
    chk("rsp_rdy", cmd_rdy, 0);
    chk("rsp_rdata", rsp_rdata, model_line());
    tick();
    clr_hub();
    chk("rsp_pulse", rsp_vld, 0);
    chk("rdy_back", cmd_rdy, 1);
  endtask

  initial begin
    logic [LW-1:0] line;
    logic [LW-1:0] seq;
    int beat;
    cmd_vld = 0; cmd_rwn = 1; cmd_burst = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wmask = 0;
    host_rxd = 0;
    clr_hub();
    model_reset();

    #12;
    check_reset_outputs("por");
    tick();
    rst = 1'b0;

    // Burst read, 8 consecutive beats 0xA000..0xA007.
    for (int i = 0; i < BEATS; i++) seq[16*i +: 16] = 16'hA000 + 16'(i);
    run_txn(1'b1, 1'b1, 32'h0000_1000, '0, '0, seq, 1, 1'b0, 0, 0);

    // Burst write 0x1111..0x8888, ack every other cycle.
    for (int i = 0; i < BEATS; i++) line[16*i +: 16] = 16'h1111 * 16'(i + 1);
    run_txn(1'b0, 1'b1, 32'h0000_2000, line, '0, '0, 0, 1'b0, 1, 1);

    // Single read of beat 0 only; other beats keep the written line.
    seq = '0;
    seq[15:0] = 16'hBEEF;
    run_txn(1'b1, 1'b0, 32'h0000_0003, '0, '0, seq, 2, 1'b0, 0, 2);

    // First read beat coincident with host_ack.
    run_txn(1'b1, 1'b1, 32'h0000_0040, '0, '0, rand_line(), 0, 1'b1, 0, 1);

    // Beat 2 masked on the high byte.
    run_txn(1'b0, 1'b1, 32'h0000_0080, rand_line(), 16'h0020, '0, 1, 1'b0, 0, 1);

    // Reset in XFER after 3 read beats aborts silently.
    cmd_vld = 1'b1; cmd_rwn = 1'b1; cmd_burst = 1'b1; cmd_addr = 32'h0000_3000;
    tick();
    cmd_vld  = 1'b0;
    host_ack = 1'b1;
    tick();
    clr_hub();
    beat = 0;
    for (int i = 0; i < 3; i++) begin
      do_beat(1'b1, rand_line(), beat);
      tick();
      clr_hub();
    end
    rst = 1'b1;
    model_reset();
    #1 check_reset_outputs("mid_rst");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_rsp", rsp_vld, 0);
      tick();
    end
    // Single read after reset: the other beats must read back as cleared.
    run_txn(1'b1, 1'b0, 32'h0000_0010, '0, '0, rand_line(), 0, 1'b0, 0, 1);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      logic rwn_r, burst_r;
      logic [31:0] addr_r;
      rwn_r   = 1'($urandom_range(0, 1));
      burst_r = 1'($urandom_range(0, 1));
      addr_r  = $urandom;
      if (burst_r) addr_r[CW-1:0] = '0;
      run_txn(rwn_r, burst_r, addr_r, rand_line(), 16'($urandom), rand_line(),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 2);
      for (int g = 0; g < $urandom_range(0, 2); g++) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
